image_pixel_packer: RTL

Downstream stage of `image_processor`. It consumes the processed 8-bit pixel stream and packs `PIX_PER_WORD` pixels into one output word for the frame writer/memory port. Both sides use valid/ready handshakes. The block marks frame boundaries, pads the final partial word, counts frames and flags frame-length errors.

---
 rtl/img_pkg.sv | 24 ++
 rtl/packer_out_reg.sv | 65 ++++++
 rtl/image_pixel_packer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/img_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : img_pkg
//  Description : Shared definitions for the image pipeline (image_processor,
//                image_pixel_packer). Holds the pixel width, the default frame
//                geometry, the pixel type and a small width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package img_pkg;

    localparam int PIXEL_W      = 8;
    localparam int IMG_W        = 256;
    localparam int IMG_H        = 256;
    localparam int FRAME_PIXELS = IMG_W * IMG_H;

    typedef logic [PIXEL_W-1:0] pixel_t;

    // Counter width for a range of 'value' states, never narrower than 1 bit
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/packer_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : packer_out_reg
//  Description : Single-entry output holding register for the pixel packer.
//                Holds data, keep and last. The upstream side may load a new
//                word whenever the register is empty or is being drained in
//                the same cycle (o_in_ready = !valid || i_out_ready).
//  Ports       : clk, rst (async, active-low)
//                i_load, i_load_data, i_load_keep, i_load_last : new word
//                i_out_ready                                   : downstream ready
//                o_out_valid, o_out_data, o_out_keep, o_out_last: held word
//                o_in_ready                                    : may load
//  Revision    : 1.0 - initial release
// ============================================================================
module packer_out_reg #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic [KEEP_W-1:0] i_load_keep,
    input  logic              i_load_last,
    input  logic              i_out_ready,
    output logic              o_out_valid,
    output logic [DATA_W-1:0] o_out_data,
    output logic [KEEP_W-1:0] o_out_keep,
    output logic              o_out_last,
    output logic              o_in_ready
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [KEEP_W-1:0] r_keep;
    logic              r_last;

    // Combinational from i_out_ready only; never depends on upstream valid
    assign o_in_ready = !r_valid || i_out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            // A load in a drain cycle replaces the word; valid stays high
            r_valid <= 1'b1;
            r_data  <= i_load_data;
            r_keep  <= i_load_keep;
            r_last  <= i_load_last;
        end else if (i_out_ready) begin
            // Payload is kept as-is; only valid drops
            r_valid <= 1'b0;
        end
    end

    assign o_out_valid = r_valid;
    assign o_out_data  = r_data;
    assign o_out_keep  = r_keep;
    assign o_out_last  = r_last;

endmodule
`default_nettype wire

// File: rtl/image_pixel_packer.sv
`default_nettype none
// ============================================================================
//  Module      : image_pixel_packer
//  Description : Packs PIX_PER_WORD pixels into one output word. Closes a word
//                on a full lane set, on in_last, or when the frame pixel count
//                reaches FRAME_PIXELS (force-close). Partial words are padded
//                with zero lanes and flagged through out_keep. Counts completed
//                frames and keeps a sticky frame-length error.
//  Ports       : clk, rst (async, active-low)
//                in_valid/in_ready/in_pixel/in_last     : pixel stream in
//                out_valid/out_ready/out_data/out_keep/out_last : words out
//                frame_done (pulse), frame_count, err_len (sticky)
//                out_checksum : only with IMG_PACKER_CHECKSUM_EN defined
//  Options     : `define IMG_PACKER_CHECKSUM_EN adds a per-frame 16-bit pixel
//                sum latched onto out_checksum with the closing word.
//  Revision    : 1.0 - initial release
// ============================================================================
module image_pixel_packer
    import img_pkg::*;
#(
    parameter int PIXEL_W      = img_pkg::PIXEL_W,
    parameter int PIX_PER_WORD = 4,       // power of two, >= 2
    parameter int FRAME_PIXELS = img_pkg::FRAME_PIXELS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [PIXEL_W-1:0]              in_pixel,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [PIXEL_W*PIX_PER_WORD-1:0] out_data,
    output logic [PIX_PER_WORD-1:0]         out_keep,
    output logic                            out_last,
    output logic                            frame_done,
    output logic [15:0]                     frame_count,
`ifdef IMG_PACKER_CHECKSUM_EN
    output logic                            err_len,
    output logic [15:0]                     out_checksum
`else
    output logic                            err_len
`endif
);

    localparam int c_DATA_W = PIXEL_W * PIX_PER_WORD;
    localparam int c_LANE_W = clog2_min1(PIX_PER_WORD);
    localparam int c_CNT_W  = clog2_min1(FRAME_PIXELS);

    localparam logic [c_LANE_W-1:0] c_LANE_MAX = c_LANE_W'(PIX_PER_WORD - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_MAX  = c_CNT_W'(FRAME_PIXELS - 1);

    // ------------------------------------------------------------------
    // Pixel side state
    // ------------------------------------------------------------------
    logic [c_DATA_W-1:0] r_acc;
    logic [c_LANE_W-1:0] r_lane;
    logic [c_CNT_W-1:0]  r_pix_cnt;
    logic                r_err_len;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_at_end;
    logic                w_close;
    logic                w_word_last;
    logic [31:0]         w_shift;
    logic [c_DATA_W-1:0] w_pix_ins;
    logic [c_DATA_W-1:0] w_lane_mask;
    logic [c_DATA_W-1:0] w_word_data;
    logic [PIX_PER_WORD-1:0] w_word_keep;

    assign w_accept    = in_valid && w_in_ready;
    assign w_at_end    = (r_pix_cnt == c_CNT_MAX);
    assign w_word_last = in_last || w_at_end;
    assign w_close     = w_accept && ((r_lane == c_LANE_MAX) || w_word_last);

    // Current pixel dropped into lane r_lane
    assign w_shift   = 32'(r_lane) * 32'(PIXEL_W);
    assign w_pix_ins = {{(c_DATA_W - PIXEL_W){1'b0}}, in_pixel} << w_shift;

    // Thermometer keep: lanes 0..r_lane set
    assign w_word_keep = {PIX_PER_WORD{1'b1}} >> (c_LANE_MAX - r_lane);

    for (genvar gi = 0; gi < PIX_PER_WORD; gi++) begin : g_lane_mask
        assign w_lane_mask[gi*PIXEL_W +: PIXEL_W] = {PIXEL_W{w_word_keep[gi]}};
    end

    // Lanes above r_lane are forced to zero so a partial word is padded
    assign w_word_data = (r_acc | w_pix_ins) & w_lane_mask;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc     <= '0;
            r_lane    <= '0;
            r_pix_cnt <= '0;
            r_err_len <= 1'b0;
        end else if (w_accept) begin
            if (w_close) begin
                r_acc  <= '0;
                r_lane <= '0;
            end else begin
                r_acc  <= w_word_data;
                r_lane <= r_lane + 1'b1;
            end
            if (w_word_last) begin
                r_pix_cnt <= '0;
            end else begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
            end
            // in_last must coincide exactly with the final frame pixel:
            // early in_last is a short frame, missing in_last a long frame
            if (in_last != w_at_end) begin
                r_err_len <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output holding register
    // ------------------------------------------------------------------
    logic                w_out_valid;
    logic                w_out_last;
    logic                w_out_xfer;
    logic                r_frame_done;
    logic [15:0]         r_frame_count;

    packer_out_reg #(
        .DATA_W (c_DATA_W),
        .KEEP_W (PIX_PER_WORD)
    ) u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_close),
        .i_load_data (w_word_data),
        .i_load_keep (w_word_keep),
        .i_load_last (w_word_last),
        .i_out_ready (out_ready),
        .o_out_valid (w_out_valid),
        .o_out_data  (out_data),
        .o_out_keep  (out_keep),
        .o_out_last  (w_out_last),
        .o_in_ready  (w_in_ready)
    );

    assign w_out_xfer = w_out_valid && out_ready && w_out_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_done <= w_out_xfer;
            if (w_out_xfer) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

`ifdef IMG_PACKER_CHECKSUM_EN
    // ------------------------------------------------------------------
    // Per-frame running pixel sum, restarted after each closing word
    // ------------------------------------------------------------------
    logic [15:0] r_sum;
    logic [15:0] r_checksum;
    logic [15:0] w_sum_next;

    assign w_sum_next = r_sum + 16'(in_pixel);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum      <= '0;
            r_checksum <= '0;
        end else if (w_accept) begin
            if (w_word_last) begin
                r_sum      <= '0;
                r_checksum <= w_sum_next;
            end else begin
                r_sum      <= w_sum_next;
            end
        end
    end

    assign out_checksum = r_checksum;
`endif

    assign in_ready    = w_in_ready;
    assign out_valid   = w_out_valid;
    assign out_last    = w_out_last;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;
    assign err_len     = r_err_len;

endmodule
`default_nettype wire
